// File: rtl/seven_segment_scan_controller_pkg.sv
// Shared definitions for the seven-segment scan controller: digit register
// field layout, reset/blank values and the scan state encoding.
package seven_segment_scan_controller_pkg;

    localparam int HEX_LSB   = 0;
    localparam int HEX_MSB   = 3;
    localparam int BLANK_BIT = 4;
    localparam int DP_BIT    = 5;
    localparam int REG_W     = 6;

    localparam logic [7:0] DIGIT_RESET = 8'h10;
    localparam logic [6:0] SEG_OFF     = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        DRIVE,
        GUARD
    } scan_state_e;

endpackage

// File: rtl/seven_segment_scan_controller_decoder.sv
// Hex nibble to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module Hexadecimal_To_Seven_Segment
    import seven_segment_scan_controller_pkg::*;
(
    input  logic [3:0] hex_i,
    output logic [6:0] seg_n_o
);

    always_comb begin
        seg_n_o = SEG_OFF;
        case (hex_i)
            4'h0: seg_n_o = 7'h40;
            4'h1: seg_n_o = 7'h79;
            4'h2: seg_n_o = 7'h24;
            4'h3: seg_n_o = 7'h30;
            4'h4: seg_n_o = 7'h19;
            4'h5: seg_n_o = 7'h12;
            4'h6: seg_n_o = 7'h02;
            4'h7: seg_n_o = 7'h78;
            4'h8: seg_n_o = 7'h00;
            4'h9: seg_n_o = 7'h10;
            4'hA: seg_n_o = 7'h08;
            4'hB: seg_n_o = 7'h03;
            4'hC: seg_n_o = 7'h46;
            4'hD: seg_n_o = 7'h21;
            4'hE: seg_n_o = 7'h06;
            4'hF: seg_n_o = 7'h0E;
            default: seg_n_o = SEG_OFF;
        endcase
    end

endmodule

// File: rtl/seven_segment_scan_controller.sv
// Multiplexed common-anode display driver: per-digit registers behind a small
// slave port, one shared decoder, and a DRIVE/GUARD scan with dead time.
module seven_segment_scan_controller
    import seven_segment_scan_controller_pkg::*;
#(
    parameter int NUM_DIGITS   = 8,
    parameter int SCAN_DIV     = 50000,
    parameter int GUARD_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [2:0]            address,
    input  logic                  write,
    input  logic [7:0]            writedata,
    input  logic                  read,
    output logic [7:0]            readdata,
    output logic [NUM_DIGITS-1:0] digit_sel_n,
    output logic [6:0]            seg_n,
    output logic                  dp_n,
    output logic [2:0]            scan_index
);

    localparam int CNT_MAX = (SCAN_DIV > GUARD_CYCLES) ? SCAN_DIV : GUARD_CYCLES;
    localparam int CNT_W   = (CNT_MAX > 2) ? $clog2(CNT_MAX) : 1;
    localparam logic [CNT_W-1:0] SCAN_LAST  = CNT_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYCLES - 1);
    localparam logic [2:0]       LAST_DIGIT = 3'(NUM_DIGITS - 1);

    logic [REG_W-1:0]      digit_q [NUM_DIGITS];
    logic [REG_W-1:0]      digit_d [NUM_DIGITS];
    logic [7:0]            readdata_q;
    logic [7:0]            readNext;

    scan_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [2:0]            scan_index_q;
    logic [NUM_DIGITS-1:0] digit_sel_n_q;
    logic [6:0]            seg_n_q;
    logic                  dp_n_q;

    logic [REG_W-1:0]      curDigit;
    logic [6:0]            decSeg;
    logic                  wdataUnused;

    assign wdataUnused = ^writedata[7:6];

    // Out-of-range addresses match no loop index, so writes drop and reads return 0.
    always_comb begin
        digit_d  = digit_q;
        readNext = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (write && address == 3'(i)) begin
                digit_d[i] = writedata[REG_W-1:0];
            end
            if (address == 3'(i)) begin
                readNext = {2'b00, digit_q[i]};
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                digit_q[i] <= DIGIT_RESET[REG_W-1:0];
            end
            readdata_q <= '0;
        end else begin
            digit_q <= digit_d;
            if (read) begin
                readdata_q <= readNext;
            end
        end
    end

    always_comb begin
        curDigit = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (scan_index_q == 3'(i)) begin
                curDigit = digit_q[i];
            end
        end
    end

    Hexadecimal_To_Seven_Segment u_decoder (
        .hex_i   (curDigit[HEX_MSB:HEX_LSB]),
        .seg_n_o (decSeg)
    );

    // Outputs are computed from the current state, so they trail state entry by one edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            scan_index_q  <= '0;
            digit_sel_n_q <= '1;
            seg_n_q       <= SEG_OFF;
            dp_n_q        <= 1'b1;
        end else if (!enable) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            scan_index_q  <= '0;
            digit_sel_n_q <= '1;
            seg_n_q       <= SEG_OFF;
            dp_n_q        <= 1'b1;
        end else begin
            case (state_q)
                IDLE: begin
                    digit_sel_n_q <= '1;
                    seg_n_q       <= SEG_OFF;
                    dp_n_q        <= 1'b1;
                    state_q       <= DRIVE;
                    cnt_q         <= '0;
                    scan_index_q  <= '0;
                end
                DRIVE: begin
                    digit_sel_n_q <= ~(NUM_DIGITS'(1) << scan_index_q);
                    seg_n_q       <= curDigit[BLANK_BIT] ? SEG_OFF : decSeg;
                    dp_n_q        <= curDigit[BLANK_BIT] | ~curDigit[DP_BIT];
                    if (cnt_q == SCAN_LAST) begin
                        state_q <= GUARD;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                GUARD: begin
                    digit_sel_n_q <= '1;
                    seg_n_q       <= SEG_OFF;
                    dp_n_q        <= 1'b1;
                    if (cnt_q == GUARD_LAST) begin
                        state_q      <= DRIVE;
                        cnt_q        <= '0;
                        scan_index_q <= (scan_index_q == LAST_DIGIT) ? 3'd0 : scan_index_q + 3'd1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q       <= IDLE;
                    cnt_q         <= '0;
                    scan_index_q  <= '0;
                    digit_sel_n_q <= '1;
                    seg_n_q       <= SEG_OFF;
                    dp_n_q        <= 1'b1;
                end
            endcase
        end
    end

    assign readdata    = readdata_q;
    assign digit_sel_n = digit_sel_n_q;
    assign seg_n       = seg_n_q;
    assign dp_n        = dp_n_q;
    assign scan_index  = scan_index_q;

endmodule

// File: tb/tb_seven_segment_scan_controller.sv
// Scoreboard bench: expected display slots and read results are queued by the
// stimulus and consumed by independent monitors watching the DUT outputs.
module tb_seven_segment_scan_controller;

    localparam int ND = 8;
    localparam int SD = 4;
    localparam int GC = 2;
    localparam logic [6:0] SEG_TAB [8] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78};

    typedef struct {
        logic [7:0]      sel;
        logic [3:0][6:0] seg;
        logic [3:0]      dp;
        int              len;
        int              gap;
    } slot_t;

    typedef struct {
        string      name;
        logic [7:0] exp;
    } rd_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       en1, wr1, rd1, en2, wr2, rd2;
    logic [2:0] addr1, addr2, scanIdx1, scanIdx2;
    logic [7:0] wdata1, wdata2, rdata1, rdata2;
    logic [7:0] sel1;
    logic [3:0] sel2;
    logic [6:0] seg1, seg2;
    logic       dp1n, dp2n;

    slot_t   slotQ [$];
    rd_exp_t readQ1 [$];
    rd_exp_t readQ2 [$];

    int checks = 0;
    int errors = 0;
    int slotsStarted = 0;
    int slotsDone = 0;

    always #5 clk = ~clk;

    seven_segment_scan_controller #(.NUM_DIGITS(ND), .SCAN_DIV(SD), .GUARD_CYCLES(GC)) dut (
        .clk(clk), .reset(reset), .enable(en1), .address(addr1), .write(wr1),
        .writedata(wdata1), .read(rd1), .readdata(rdata1), .digit_sel_n(sel1),
        .seg_n(seg1), .dp_n(dp1n), .scan_index(scanIdx1)
    );

    seven_segment_scan_controller #(.NUM_DIGITS(4), .SCAN_DIV(SD), .GUARD_CYCLES(GC)) dutSmall (
        .clk(clk), .reset(reset), .enable(en2), .address(addr2), .write(wr2),
        .writedata(wdata2), .read(rd2), .readdata(rdata2), .digit_sel_n(sel2),
        .seg_n(seg2), .dp_n(dp2n), .scan_index(scanIdx2)
    );

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic slot_t mkSlot(input int digit, input logic [6:0] seg, input logic dp,
                                     input int len, input int gap);
        slot_t s;
        s.sel = ~(8'h01 << digit);
        s.seg = {4{seg}};
        s.dp  = {4{dp}};
        s.len = len;
        s.gap = gap;
        return s;
    endfunction

    // One bus cycle on the chosen instance; a read queues its hand-computed result.
    task automatic applyStimulus(input int which, input bit wr, input bit rd, input logic [2:0] a,
                                 input logic [7:0] d, input logic [7:0] expRd, input string name);
        rd_exp_t e;
        e.name = name;
        e.exp  = expRd;
        @(posedge clk);
        #1;
        if (which == 1) begin
            addr1 = a; wdata1 = d; wr1 = wr; rd1 = rd;
            if (rd) readQ1.push_back(e);
        end else begin
            addr2 = a; wdata2 = d; wr2 = wr; rd2 = rd;
            if (rd) readQ2.push_back(e);
        end
        @(posedge clk);
        #1;
        wr1 = 1'b0; rd1 = 1'b0; wr2 = 1'b0; rd2 = 1'b0;
    endtask

    task automatic waitCount(input string what, input bit useDone, input int target);
        int cnt;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            #2;
            cnt = useDone ? slotsDone : slotsStarted;
            if (cnt >= target) return;
        end
        cnt = useDone ? slotsDone : slotsStarted;
        checkOutput($sformatf("timeout_%s", what), 32'(cnt), 32'(target));
    endtask

    // Display monitor: each lit slot is matched cycle by cycle against the next queued slot.
    initial begin
        bit    inSlot = 1'b0;
        bit    haveExp = 1'b0;
        int    pos = 0;
        int    darkRun = 0;
        logic [7:0] curSel = 8'hFF;
        slot_t cur;
        forever begin
            @(negedge clk);
            if (reset) begin
                inSlot  = 1'b0;
                darkRun = 0;
            end else if (sel1 != 8'hFF) begin
                if (!inSlot || sel1 != curSel) begin
                    if (inSlot) begin
                        if (haveExp) checkOutput("slotLen", 32'(pos), 32'(cur.len));
                        slotsDone++;
                    end
                    if (slotQ.size() == 0) begin
                        haveExp = 1'b0;
                        checkOutput("unexpectedSlot", 32'(sel1), 32'hFF);
                    end else begin
                        cur     = slotQ.pop_front();
                        haveExp = 1'b1;
                        if (cur.gap >= 0) checkOutput("guardLen", 32'(darkRun), 32'(cur.gap));
                    end
                    inSlot = 1'b1;
                    curSel = sel1;
                    pos    = 0;
                    slotsStarted++;
                end
                if (haveExp && pos < 4) begin
                    checkOutput($sformatf("slot%0d_sel_p%0d", slotsStarted - 1, pos), 32'(sel1), 32'(cur.sel));
                    checkOutput($sformatf("slot%0d_seg_p%0d", slotsStarted - 1, pos), 32'(seg1), 32'(cur.seg[pos]));
                    checkOutput($sformatf("slot%0d_dp_p%0d", slotsStarted - 1, pos), 32'(dp1n), 32'(cur.dp[pos]));
                end
                pos++;
                darkRun = 0;
            end else begin
                if (inSlot) begin
                    if (haveExp) checkOutput($sformatf("slot%0d_len", slotsStarted - 1), 32'(pos), 32'(cur.len));
                    inSlot = 1'b0;
                    slotsDone++;
                end
                checkOutput("darkSeg", 32'(seg1), 32'h7F);
                checkOutput("darkDp", 32'(dp1n), 32'h1);
                darkRun++;
            end
        end
    end

    // Read monitor: a read strobe seen at an edge means readdata is due before the next edge.
    initial begin
        bit p1, p2;
        rd_exp_t e;
        forever begin
            @(posedge clk);
            p1 = rd1;
            p2 = rd2;
            @(negedge clk);
            if (p1) begin
                if (readQ1.size() == 0) checkOutput("unexpectedRead1", 32'(rdata1), 32'hFFFF);
                else begin
                    e = readQ1.pop_front();
                    checkOutput(e.name, 32'(rdata1), 32'(e.exp));
                end
            end
            if (p2) begin
                if (readQ2.size() == 0) checkOutput("unexpectedRead2", 32'(rdata2), 32'hFFFF);
                else begin
                    e = readQ2.pop_front();
                    checkOutput(e.name, 32'(rdata2), 32'(e.exp));
                end
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        slot_t s;
        reset = 1'b1; en1 = 1'b1; en2 = 1'b0;
        wr1 = 1'b0; rd1 = 1'b0; addr1 = '0; wdata1 = '0;
        wr2 = 1'b0; rd2 = 1'b0; addr2 = '0; wdata2 = '0;

        @(negedge clk);
        checkOutput("rstSel", 32'(sel1), 32'hFF);
        checkOutput("rstSeg", 32'(seg1), 32'h7F);
        checkOutput("rstDp", 32'(dp1n), 32'h1);
        checkOutput("rstRead", 32'(rdata1), 32'h0);
        checkOutput("rstScan", 32'(scanIdx1), 32'h0);
        checkOutput("rstSelSmall", 32'(sel2), 32'hF);
        checkOutput("rstReadSmall", 32'(rdata2), 32'h0);

        // All digits blank after reset: one full scan of dark segments.
        for (int i = 0; i < ND; i++) slotQ.push_back(mkSlot(i, 7'h7F, 1'b1, SD, (i == 0) ? -1 : GC));
        #1 reset = 1'b0;
        waitCount("blankScan", 1'b1, 8);
        @(posedge clk);
        #1;
        checkOutput("wrapScanIdx", 32'(scanIdx1), 32'h0);
        en1 = 1'b0;

        for (int i = 0; i < ND; i++) applyStimulus(1, 1'b1, 1'b0, 3'(i), 8'(i), 8'h00, "wrHex");

        for (int i = 0; i < ND; i++) slotQ.push_back(mkSlot(i, SEG_TAB[i], 1'b1, SD, (i == 0) ? -1 : GC));
        for (int i = 0; i < 3; i++) slotQ.push_back(mkSlot(i, SEG_TAB[i], 1'b1, SD, GC));
        s = mkSlot(3, SEG_TAB[3], 1'b1, SD, GC);
        s.seg[3] = 7'h08;
        s.dp[3]  = 1'b0;
        slotQ.push_back(s);
        for (int i = 4; i < ND; i++) slotQ.push_back(mkSlot(i, SEG_TAB[i], 1'b1, SD, GC));
        for (int i = 0; i < 3; i++) slotQ.push_back(mkSlot(i, SEG_TAB[i], 1'b1, SD, GC));
        s = mkSlot(3, 7'h08, 1'b0, SD, GC);
        s.seg[3] = 7'h7F;
        s.dp[3]  = 1'b1;
        slotQ.push_back(s);
        slotQ.push_back(mkSlot(4, SEG_TAB[4], 1'b1, SD, GC));
        slotQ.push_back(mkSlot(5, SEG_TAB[5], 1'b1, 2, GC));

        @(posedge clk);
        #1 en1 = 1'b1;

        waitCount("digit3First", 1'b0, 20);
        applyStimulus(1, 1'b1, 1'b0, 3'd3, 8'h2A, 8'h00, "wrA");
        applyStimulus(1, 1'b0, 1'b1, 3'd3, 8'h00, 8'h2A, "rdA");

        waitCount("digit3Second", 1'b0, 28);
        applyStimulus(1, 1'b1, 1'b0, 3'd3, 8'h1A, 8'h00, "wrBlank");

        waitCount("digit5", 1'b0, 30);
        @(posedge clk);
        #1 en1 = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("cutSel", 32'(sel1), 32'hFF);
        checkOutput("cutScan", 32'(scanIdx1), 32'h0);

        slotQ.push_back(mkSlot(0, SEG_TAB[0], 1'b1, SD, -1));
        slotQ.push_back(mkSlot(1, SEG_TAB[1], 1'b1, SD, GC));
        @(posedge clk);
        #1 en1 = 1'b1;

        // Land mid-guard after digit 1, then reset asynchronously.
        waitCount("restart", 1'b1, 32);
        checkOutput("preRstScan", 32'(scanIdx1), 32'h1);
        reset = 1'b1;
        en1   = 1'b0;
        #1;
        checkOutput("asyncSel", 32'(sel1), 32'hFF);
        checkOutput("asyncSeg", 32'(seg1), 32'h7F);
        checkOutput("asyncDp", 32'(dp1n), 32'h1);
        checkOutput("asyncScan", 32'(scanIdx1), 32'h0);
        checkOutput("asyncRead", 32'(rdata1), 32'h0);
        @(negedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < ND; i++) applyStimulus(1, 1'b0, 1'b1, 3'(i), 8'h00, 8'h10, $sformatf("rdRst%0d", i));

        applyStimulus(2, 1'b1, 1'b0, 3'd7, 8'h05, 8'h00, "wrOor");
        applyStimulus(2, 1'b0, 1'b1, 3'd7, 8'h00, 8'h00, "rdOor");
        applyStimulus(2, 1'b0, 1'b1, 3'd3, 8'h00, 8'h10, "rdSmall3");
        applyStimulus(2, 1'b1, 1'b0, 3'd2, 8'hE5, 8'h00, "wrMask");
        applyStimulus(2, 1'b0, 1'b1, 3'd2, 8'h00, 8'h25, "rdMask");
        applyStimulus(2, 1'b1, 1'b1, 3'd1, 8'h07, 8'h10, "rwSameOld");
        applyStimulus(2, 1'b0, 1'b1, 3'd1, 8'h00, 8'h07, "rdAfterRw");

        repeat (3) @(posedge clk);
        #1;
        checkOutput("slotQEmpty", 32'(slotQ.size()), 32'h0);
        checkOutput("readQ1Empty", 32'(readQ1.size()), 32'h0);
        checkOutput("readQ2Empty", 32'(readQ2.size()), 32'h0);
        checkOutput("smallDark", 32'(sel2), 32'hF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
